// File: rtl/baud_ctrl.sv
// baud_ctrl -- sequences a baud-rate change for a UART baud clock divider.
//
// A request (cfg_req/cfg_ack 4-phase handshake) latches the requested rate,
// waits for both UART directions to go idle (bounded by IDLE_TIMEOUT), then
// loads the divider half-period limit while holding the divider in reset for
// HOLD_CYCLES. It then waits SETTLE_CYCLES before reporting the new rate as
// valid and acknowledging.
//
// Optional feature macro: BAUD_CUSTOM_EN
//   When defined, adds input cust_lim; baud_sel=7 then uses the cust_lim
//   value latched at acceptance. A cust_lim value below 2 is rejected
//   immediately with cfg_err and count_lim unchanged.
//
// Ports:
//   CLK100MHZ   in   system clock, rising edge
//   resetn      in   synchronous active-low reset
//   baud_sel    in   [2:0] requested rate index
//   cfg_req     in   configuration request
//   busy_tx     in   UART transmitter busy
//   busy_rx     in   UART receiver busy
//   cust_lim    in   [11:0] custom limit (BAUD_CUSTOM_EN only)
//   count_lim   out  [11:0] divider half-period limit
//   div_resetn  out  active-low divider reset
//   rate_valid  out  count_lim applied and divider settled
//   cfg_ack     out  request complete, held until cfg_req drops
//   cfg_err     out  last request failed, sticky until next acceptance

module baud_ctrl #(
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned IDLE_TIMEOUT  = 4095
) (
  input  logic        CLK100MHZ,
  input  logic        resetn,
  input  logic [2:0]  baud_sel,
  input  logic        cfg_req,
  input  logic        busy_tx,
  input  logic        busy_rx,
`ifdef BAUD_CUSTOM_EN
  input  logic [11:0] cust_lim,
`endif
  output logic [11:0] count_lim,
  output logic        div_resetn,
  output logic        rate_valid,
  output logic        cfg_ack,
  output logic        cfg_err
);

  localparam int unsigned MAX_A = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_C = (MAX_A > IDLE_TIMEOUT) ? MAX_A : IDLE_TIMEOUT;
  localparam int unsigned CW    = (MAX_C < 2) ? 1 : $clog2(MAX_C + 1);

  localparam logic [11:0] RESET_LIM = 12'd326;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_HOLD,
    S_SETTLE,
    S_DONE
  } state_t;

  function automatic logic [11:0] rate_lim(input logic [2:0] sel);
    logic [11:0] lim;
    case (sel)
      3'd0:    lim = 12'd2604;
      3'd1:    lim = 12'd1302;
      3'd2:    lim = 12'd651;
      3'd3:    lim = 12'd326;
      3'd4:    lim = 12'd163;
      3'd5:    lim = 12'd81;
      3'd6:    lim = 12'd54;
      default: lim = 12'd27;
    endcase
    return lim;
  endfunction

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0] pend_q, pend_d;
  logic [11:0] count_lim_q, count_lim_d;
  logic        div_resetn_q, div_resetn_d;
  logic        rate_valid_q, rate_valid_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;

  logic [11:0] sel_lim;
  logic        bad_custom;

`ifdef BAUD_CUSTOM_EN
  assign sel_lim    = (baud_sel == 3'd7) ? cust_lim : rate_lim(baud_sel);
  assign bad_custom = (baud_sel == 3'd7) && (cust_lim < 12'd2);
`else
  assign sel_lim    = rate_lim(baud_sel);
  assign bad_custom = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    count_lim_d  = count_lim_q;
    div_resetn_d = div_resetn_q;
    rate_valid_d = rate_valid_q;
    ack_d        = ack_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        div_resetn_d = 1'b1;
        ack_d        = 1'b0;
        if (cfg_req) begin
          pend_d = sel_lim;
          err_d  = 1'b0;
          cnt_d  = '0;
          if (bad_custom) begin
            // Invalid custom limit: reject without touching the divider.
            state_d      = S_DONE;
            err_d        = 1'b1;
            rate_valid_d = 1'b1;
            ack_d        = 1'b1;
          end else begin
            state_d      = S_WAIT_IDLE;
            rate_valid_d = 1'b0;
          end
        end
      end

      S_WAIT_IDLE: begin
        if (!busy_tx && !busy_rx) begin
          state_d      = S_HOLD;
          count_lim_d  = pend_q;
          div_resetn_d = 1'b0;
          cnt_d        = '0;
        end else if (cnt_q == CW'(IDLE_TIMEOUT - 1)) begin
          state_d      = S_DONE;
          err_d        = 1'b1;
          rate_valid_d = 1'b1;
          ack_d        = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_HOLD: begin
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          state_d      = S_SETTLE;
          div_resetn_d = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          state_d      = S_DONE;
          rate_valid_d = 1'b1;
          ack_d        = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        if (!cfg_req) begin
          state_d = S_IDLE;
          ack_d   = 1'b0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pend_q       <= RESET_LIM;
      count_lim_q  <= RESET_LIM;
      div_resetn_q <= 1'b0;
      rate_valid_q <= 1'b1;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      count_lim_q  <= count_lim_d;
      div_resetn_q <= div_resetn_d;
      rate_valid_q <= rate_valid_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
    end
  end

  assign count_lim  = count_lim_q;
  assign div_resetn = div_resetn_q;
  assign rate_valid = rate_valid_q;
  assign cfg_ack    = ack_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_baud_ctrl.sv
// tb_baud_ctrl -- directed self-checking bench for baud_ctrl (default params).
// Cycle numbering for ack latency: the acceptance edge is cycle 1.

module tb_baud_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  baud_sel;
  logic        cfg_req;
  logic        busy_tx;
  logic        busy_rx;
`ifdef BAUD_CUSTOM_EN
  logic [11:0] cust_lim;
`endif
  logic [11:0] count_lim;
  logic        div_resetn;
  logic        rate_valid;
  logic        cfg_ack;
  logic        cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  baud_ctrl #(
    .HOLD_CYCLES  (4),
    .SETTLE_CYCLES(16),
    .IDLE_TIMEOUT (4095)
  ) dut (
    .CLK100MHZ (clk),
    .resetn    (resetn),
    .baud_sel  (baud_sel),
    .cfg_req   (cfg_req),
    .busy_tx   (busy_tx),
    .busy_rx   (busy_rx),
`ifdef BAUD_CUSTOM_EN
    .cust_lim  (cust_lim),
`endif
    .count_lim (count_lim),
    .div_resetn(div_resetn),
    .rate_valid(rate_valid),
    .cfg_ack   (cfg_ack),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until cfg_ack is seen; n = edges elapsed (bounded by max_cyc).
  task automatic wait_ack(input int max_cyc, output int n);
    n = 0;
    while (!cfg_ack && n < max_cyc) begin
      tick();
      n++;
    end
  endtask

  task automatic release_req();
    cfg_req = 1'b0;
    tick();
    check_eq("ack_drop", cfg_ack, 0);
  endtask

  initial begin
    int n, k, lowc, ack_k, hold_k, acks;

    resetn   = 1'b0;
    baud_sel = 3'd0;
    cfg_req  = 1'b0;
    busy_tx  = 1'b0;
    busy_rx  = 1'b0;
`ifdef BAUD_CUSTOM_EN
    cust_lim = 12'd0;
`endif

    // Reset state
    tick(); tick(); tick();
    check_eq("rst_lim",   count_lim, 326);
    check_eq("rst_valid", rate_valid, 1);
    check_eq("rst_ack",   cfg_ack, 0);
    check_eq("rst_err",   cfg_err, 0);
    check_eq("rst_divrn", div_resetn, 0);
    resetn = 1'b1;
    tick();
    check_eq("rel_divrn", div_resetn, 1);

    // Idle UART, sel 7: 4 cycles of divider reset, ack on cycle 22
    baud_sel = 3'd7;
    cfg_req  = 1'b1;
    tick();
    check_eq("acc_valid", rate_valid, 0);
    baud_sel = 3'd0;              // must be ignored after acceptance
    k = 1; lowc = 0; ack_k = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      k++;
      if (!div_resetn) lowc++;
      if (cfg_ack && ack_k == 0) ack_k = k;
    end
    check_eq("s7_ackcyc", ack_k, 22);
    check_eq("s7_lowcnt", lowc, 4);
    check_eq("s7_lim",    count_lim, 27);
    check_eq("s7_valid",  rate_valid, 1);
    check_eq("s7_err",    cfg_err, 0);
    check_eq("s7_ackhold", cfg_ack, 1);
    release_req();

    // Same rate again still runs the full sequence
    baud_sel = 3'd7;
    cfg_req  = 1'b1;
    tick();
    check_eq("same_valid0", rate_valid, 0);
    wait_ack(100, n);
    check_eq("same_ackcyc", n, 21);
    check_eq("same_lim", count_lim, 27);
    release_req();

    // busy_tx for 100 cycles, then HOLD on the first idle edge
    busy_tx  = 1'b1;
    baud_sel = 3'd2;
    cfg_req  = 1'b1;
    tick();
    for (int i = 0; i < 99; i++) tick();
    check_eq("busy_lim",   count_lim, 27);
    check_eq("busy_divrn", div_resetn, 1);
    check_eq("busy_valid", rate_valid, 0);
    busy_tx = 1'b0;
    k = 0; hold_k = 0; ack_k = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      k++;
      if (!div_resetn && hold_k == 0) hold_k = k;
      if (cfg_ack && ack_k == 0) ack_k = k;
    end
    check_eq("busy_hold1", hold_k, 1);
    check_eq("busy_ack20", ack_k - hold_k, 20);
    check_eq("busy_lim2",  count_lim, 651);
    release_req();

    // busy_rx stuck: timeout after 4095 cycles, limit unchanged
    busy_rx  = 1'b1;
    baud_sel = 3'd0;
    cfg_req  = 1'b1;
    tick();
    wait_ack(5000, n);
    check_eq("to_cycles", n, 4095);
    check_eq("to_err",    cfg_err, 1);
    check_eq("to_ack",    cfg_ack, 1);
    check_eq("to_valid",  rate_valid, 1);
    check_eq("to_lim",    count_lim, 651);
    check_eq("to_divrn",  div_resetn, 1);
    release_req();
    check_eq("to_sticky", cfg_err, 1);
    busy_rx = 1'b0;

    // Next acceptance clears cfg_err; reset during SETTLE aborts
    baud_sel = 3'd3;
    cfg_req  = 1'b1;
    tick();
    check_eq("acc_errclr", cfg_err, 0);
    for (int i = 0; i < 10; i++) tick();   // HOLD ends at cycle 5, now in SETTLE
    check_eq("settle_divrn", div_resetn, 1);
    resetn  = 1'b0;
    cfg_req = 1'b0;
    tick();
    resetn = 1'b1;
    check_eq("abort_lim",   count_lim, 326);
    check_eq("abort_valid", rate_valid, 1);
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cfg_ack) acks++;
    end
    check_eq("abort_noack", acks, 0);

    // Ack drop in DONE; a new request needs cfg_req reasserted
    baud_sel = 3'd4;
    cfg_req  = 1'b1;
    tick();
    wait_ack(100, n);
    check_eq("s4_ackcyc", n, 21);
    check_eq("s4_lim", count_lim, 163);
    release_req();
    baud_sel = 3'd5;
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cfg_ack || !rate_valid) acks++;
    end
    check_eq("noreq_idle", acks, 0);
    check_eq("noreq_lim", count_lim, 163);
    cfg_req = 1'b1;
    tick();
    wait_ack(100, n);
    check_eq("s5_ackcyc", n, 21);
    check_eq("s5_lim", count_lim, 81);
    release_req();

`ifdef BAUD_CUSTOM_EN
    // Custom limit below 2 rejected immediately
    baud_sel = 3'd7;
    cust_lim = 12'd1;
    cfg_req  = 1'b1;
    tick();
    check_eq("cust1_ack", cfg_ack, 1);
    check_eq("cust1_err", cfg_err, 1);
    check_eq("cust1_lim", count_lim, 81);
    release_req();
    cust_lim = 12'd100;
    cfg_req  = 1'b1;
    tick();
    cust_lim = 12'd5;             // latched at acceptance, change ignored
    wait_ack(100, n);
    check_eq("cust100_ackcyc", n, 21);
    check_eq("cust100_lim", count_lim, 100);
    check_eq("cust100_err", cfg_err, 0);
    release_req();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/baud_ctrl.md
BAUD_CTRL -- requirements
Module: baud_ctrl

Interface
REQ-001 Parameters SHALL be: HOLD_CYCLES, default 4, number of cycles div_resetn is held low; SETTLE_CYCLES, default 16, number of cycles waited after divider release; IDLE_TIMEOUT, default 4095, maximum wait for UART idle.
REQ-002 CLK100MHZ  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 resetn  in  1  reset; SHALL be synchronous and active-low.
REQ-004 baud_sel  in  3  requested rate index, sampled when a request is accepted.
REQ-005 cfg_req  in  1  configuration request; 4-phase level handshake with cfg_ack.
REQ-006 busy_tx, busy_rx  in  1 each  UART transmitter/receiver activity flags; high = busy.
REQ-007 count_lim  out  12  half-period limit driven to the baud clock divider.
REQ-008 div_resetn  out  1  active-low synchronous reset for the baud clock divider.
REQ-009 rate_valid  out  1  high when count_lim is applied and the divider has settled.
REQ-010 cfg_ack  out  1  request complete; held high until cfg_req is low.
REQ-011 cfg_err  out  1  last request failed on idle timeout; sticky until the next accepted request.

Function
REQ-012 Rate table (baud_sel -> count_lim) SHALL be: 0->2604, 1->1302, 2->651, 3->326, 4->163, 5->81, 6->54, 7->27 (16x oversample, 1200..115200 baud).
REQ-013 FSM states SHALL be IDLE, WAIT_IDLE, HOLD, SETTLE, DONE; all outputs SHALL be registered.
REQ-014 IDLE: cfg_req=1 SHALL be accepted: baud_sel is latched, cfg_err clears, rate_valid drops, and the FSM enters WAIT_IDLE on the next edge.
REQ-015 cfg_req SHALL be ignored in every state except IDLE and DONE; baud_sel changes after acceptance SHALL have no effect.
REQ-016 WAIT_IDLE: on the first cycle with busy_tx=0 and busy_rx=0, the FSM SHALL enter HOLD, load count_lim from the table, and drive div_resetn=0.
REQ-017 WAIT_IDLE timeout: after IDLE_TIMEOUT cycles without idle, the FSM SHALL enter DONE with cfg_err=1, rate_valid=1, and count_lim unchanged.
REQ-018 HOLD SHALL last exactly HOLD_CYCLES cycles with div_resetn=0, then enter SETTLE with div_resetn=1.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then enter DONE with rate_valid=1 and cfg_ack=1.
REQ-020 DONE: cfg_ack SHALL stay 1 while cfg_req=1; when cfg_req=0, cfg_ack SHALL drop and the FSM SHALL return to IDLE on the same edge.
REQ-021 Requesting the currently applied rate SHALL still execute the full sequence.
REQ-022 With default parameters and both busy flags low, cfg_ack SHALL rise 1+1+4+16 = 22 cycles after the acceptance edge.
REQ-023 The cycle counter SHALL be shared between states, clear on every state entry, and be wide enough for IDLE_TIMEOUT without wrap-around.

Reset
REQ-024 With resetn=0 at a rising edge, the FSM SHALL go to IDLE, count_lim to 326 (9600 baud), and div_resetn, cfg_ack, cfg_err to 0; rate_valid SHALL be 1.
REQ-025 On the first edge after reset release, div_resetn SHALL go to 1; reset asserted mid-sequence SHALL abort the sequence with no cfg_ack.

Configuration
REQ-026 Macro BAUD_CUSTOM_EN, when defined, SHALL add input cust_lim[11:0], and baud_sel=7 SHALL use the cust_lim value latched at acceptance.
REQ-027 With BAUD_CUSTOM_EN defined, a cust_lim value below 2 SHALL skip WAIT_IDLE/HOLD/SETTLE and go directly to DONE with cfg_err=1 and count_lim unchanged.
REQ-028 Without BAUD_CUSTOM_EN, the cust_lim port SHALL be absent and baud_sel=7 SHALL map to 27.

Verification
REQ-029 Reset -> count_lim=326, rate_valid=1, cfg_ack=0, cfg_err=0, and div_resetn=1 one cycle after release.
REQ-030 Idle UART, baud_sel=7, cfg_req pulse held to ack -> count_lim=27, div_resetn low for exactly 4 cycles, and cfg_ack rising at cycle 22.
REQ-031 busy_tx=1 for 100 cycles, then 0 -> HOLD entered on the first idle cycle; cfg_ack rises 20 cycles later.
REQ-032 busy_rx stuck at 1 -> cfg_err=1 and cfg_ack=1 after 4095 cycles; count_lim unchanged; the next accepted request clears cfg_err.
REQ-033 Reset asserted during SETTLE -> IDLE, count_lim=326, no cfg_ack; cfg_req held low in DONE clears ack, and a second request requires cfg_req to be reasserted.
REQ-034 BAUD_CUSTOM_EN defined: cust_lim=1 with sel 7 -> cfg_err=1; cust_lim=100 -> count_lim=100.
